counter_modn: RTL

COUNTER_MODN -- requirements
Module: counter_modn

---
 rtl/counter_modn.sv | 76 +++++++
 1 files changed

// File: rtl/counter_modn.sv
// rtl/counter_modn.sv - modulo-N counter with clear, clamped load, cascade enable and wrap pulse.
// Define COUNTER_MODN_UPDOWN_EN to honour UP; otherwise the block counts up only.
module counter_modn #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             SCLR,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic [WIDTH-1:0] step_w;
  logic             at_end_w;

`ifdef COUNTER_MODN_UPDOWN_EN
  always_comb begin
    if (UP) begin
      at_end_w = (q_q == MAX_C);
      step_w   = at_end_w ? '0 : q_q + WIDTH'(1);
    end else begin
      at_end_w = (q_q == '0);
      step_w   = at_end_w ? MAX_C : q_q - WIDTH'(1);
    end
  end
`else
  logic unused_up;
  assign unused_up = UP;

  always_comb begin
    at_end_w = (q_q == MAX_C);
    step_w   = at_end_w ? '0 : q_q + WIDTH'(1);
  end
`endif

  // Wrap is flagged only for a real count step, never for load or clear.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (SCLR) begin
      q_d = '0;
    end else if (L) begin
      q_d = (D > MAX_C) ? MAX_C : D;
    end else if (CE) begin
      q_d    = step_w;
      wrap_d = at_end_w;
    end
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign TC   = CLR_N & at_end_w;
  assign CEO  = TC & CE;

endmodule
